// File: rtl/xgriscv_lsu.sv
// RV32I load/store unit: EX handshake to a word-aligned data-memory bus, with load extension and a bus timeout.
// Define XGRISCV_LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of silently aligning them.
module xgriscv_lsu #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_load,
    input  logic            ex_store,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [3:0]      dm_be,
    output logic [XLEN-1:0] dm_wdata,
    input  logic            dm_gnt,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            lsu_err,
    output logic [XLEN-1:0] err_addr
);
    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state_q, state_d;

    logic             is_store_q, mis_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [XLEN-1:0]  addr_q;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept_c, done_load_c, abort_c, misaligned_c, last_c;
    logic [1:0]       off_c;
    logic [3:0]       be_c;
    logic [XLEN-1:0]  wdata_c, rshift_c, load_c;

    // Request shaping from the EX-side operands (funct3[1:0]: 00 byte, 01 half, else word)
    always_comb begin
        off_c        = ex_addr[1:0];
        be_c         = 4'b1111;
        wdata_c      = ex_wdata;
        misaligned_c = 1'b0;
        case (ex_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ex_addr[1:0];
                wdata_c = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                off_c        = {ex_addr[1], 1'b0};
                be_c         = ex_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c      = {2{ex_wdata[15:0]}};
                misaligned_c = ex_addr[0];
            end
            default: begin
                off_c        = 2'b00;
                misaligned_c = |ex_addr[1:0];
            end
        endcase
`ifndef XGRISCV_LSU_MISALIGN_TRAP_EN
        misaligned_c = 1'b0;
`endif
    end

    // Load data alignment and sign/zero extension
    always_comb begin
        rshift_c = dm_rdata >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   load_c = funct3_q[2] ? {{(XLEN-8){1'b0}}, rshift_c[7:0]}
                                          : {{(XLEN-8){rshift_c[7]}}, rshift_c[7:0]};
            2'b01:   load_c = funct3_q[2] ? {{(XLEN-16){1'b0}}, rshift_c[15:0]}
                                          : {{(XLEN-16){rshift_c[15]}}, rshift_c[15:0]};
            default: load_c = rshift_c;
        endcase
    end

    assign last_c = (cnt_q == CNT_LAST);

    // Next-state and control strobes
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        done_load_c = 1'b0;
        abort_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid && (ex_load || ex_store)) begin
                    accept_c = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (mis_q || last_c) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                end else if (dm_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dm_rvalid) begin
                    if (is_store_q) begin
                        state_d = IDLE;
                    end else begin
                        done_load_c = 1'b1;
                        state_d     = RESP;
                    end
                end else if (last_c) begin
                    abort_c = 1'b1;
                    state_d = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured operation, bus request and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ready   <= 1'b1;
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= '0;
            dm_be      <= '0;
            dm_wdata   <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            lsu_err    <= 1'b0;
            err_addr   <= '0;
            is_store_q <= 1'b0;
            mis_q      <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            addr_q     <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            ex_ready <= (state_d == IDLE);
            dm_req   <= (state_d == REQ) && !(accept_c && misaligned_c);
            wb_valid <= done_load_c;
            lsu_err  <= abort_c;
            if (state_q == REQ || state_q == WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept_c) begin
                is_store_q <= ex_store;
                mis_q      <= misaligned_c;
                funct3_q   <= ex_funct3;
                off_q      <= off_c;
                addr_q     <= ex_addr;
                rd_q       <= ex_rd;
                cnt_q      <= '0;
                dm_we      <= ex_store;
                dm_addr    <= {ex_addr[XLEN-1:2], 2'b00};
                dm_be      <= be_c;
                dm_wdata   <= wdata_c;
            end
            if (done_load_c) begin
                wb_data <= load_c;
                wb_rd   <= rd_q;
            end
            if (abort_c) begin
                err_addr <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Randomized self-checking bench for xgriscv_lsu against a byte-level reference model.
// Honours XGRISCV_LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_xgriscv_lsu;
    localparam int unsigned XLEN = 32;
    localparam int unsigned TO   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            ex_valid, ex_ready, ex_load, ex_store;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_addr, ex_wdata;
    logic [4:0]      ex_rd;
    logic            dm_req, dm_we;
    logic [XLEN-1:0] dm_addr, dm_wdata;
    logic [3:0]      dm_be;
    logic            dm_gnt, dm_rvalid;
    logic [XLEN-1:0] dm_rdata;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            lsu_err;
    logic [XLEN-1:0] err_addr;

    always #5 clk = ~clk;

    xgriscv_lsu #(.XLEN(XLEN), .RESP_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lsu_err(lsu_err), .err_addr(err_addr)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] err_addr_m = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One memory op: gd = cycles dm_gnt is withheld, rdl = cycles between grant and dm_rvalid
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, input int gd,
                          input int rdl, input logic [31:0] rdata);
        int          n, off, m;
        bit          sgn, trap, ok;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd, e_ld;
        logic [7:0]  rbyte [4];
        case (f3)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            default:        n = 4;
        endcase
        sgn  = (f3 == 3'b000) || (f3 == 3'b001);
        off  = int'(addr % 4);
        trap = 1'b0;
`ifdef XGRISCV_LSU_MISALIGN_TRAP_EN
        trap = (off % n) != 0;
`endif
        off    = off - (off % n);
        e_addr = addr - (addr % 4);
        for (int i = 0; i < 4; i++) begin
            rbyte[i]       = rdata[8*i +: 8];
            e_be[i]        = (i >= off) && (i < off + n);
            e_wd[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        e_ld = '0;
        for (int j = 0; j < n; j++) e_ld[8*j +: 8] = rbyte[off + j];
        if (sgn && n < 4 && e_ld[8*n-1]) begin
            for (int j = n; j < 4; j++) e_ld[8*j +: 8] = 8'hFF;
        end

        chk("ready_idle", ex_ready, 1);
        ex_valid  = 1'b1;
        ex_store  = st;
        ex_load   = st ? 1'($urandom % 2) : 1'b1;
        ex_funct3 = f3;
        ex_addr   = addr;
        ex_wdata  = wd;
        ex_rd     = rd;
        step();
        ex_valid = 1'b0;
        ex_load  = 1'b0;
        ex_store = 1'b0;
        ex_addr  = $urandom;
        ex_wdata = $urandom;

        if (trap) begin
            chk("trap_noreq", dm_req, 0);
            chk("trap_busy", ex_ready, 0);
            step();
            chk("trap_err", lsu_err, 1);
            chk("trap_eaddr", err_addr, addr);
            chk("trap_nowb", wb_valid, 0);
            err_addr_m = addr;
            step();
            chk("trap_errclr", lsu_err, 0);
            chk("trap_ready", ex_ready, 1);
        end else begin
            ok = (gd + rdl + 2) <= int'(TO);
            m  = ok ? gd + rdl + 2 : int'(TO);
            for (int i = 1; i <= m; i++) begin
                chk("busy", ex_ready, 0);
                chk("no_wb", wb_valid, 0);
                if (i <= gd + 1) begin
                    chk("req", dm_req, 1);
                    if (i == 1) begin
                        chk("dm_addr", dm_addr, e_addr);
                        chk("dm_be", 32'(dm_be), 32'(e_be));
                        chk("dm_we", dm_we, 32'(st));
                        if (st) chk("dm_wdata", dm_wdata, e_wd);
                    end
                    dm_gnt    = (i == gd + 1);
                    dm_rvalid = 1'($urandom % 2);
                    dm_rdata  = $urandom;
                end else begin
                    chk("req_drop", dm_req, 0);
                    dm_gnt    = 1'b0;
                    dm_rvalid = (i == gd + rdl + 2);
                    dm_rdata  = dm_rvalid ? rdata : $urandom;
                end
                step();
            end
            dm_gnt    = 1'b0;
            dm_rvalid = 1'($urandom % 2);
            dm_rdata  = $urandom;
            if (!ok) begin
                chk("to_err", lsu_err, 1);
                chk("to_eaddr", err_addr, addr);
                chk("to_nowb", wb_valid, 0);
                chk("to_ready", ex_ready, 1);
                chk("to_noreq", dm_req, 0);
                err_addr_m = addr;
            end else if (st) begin
                chk("st_nowb", wb_valid, 0);
                chk("st_ready", ex_ready, 1);
                chk("st_noerr", lsu_err, 0);
                chk("st_eaddr", err_addr, err_addr_m);
            end else begin
                chk("ld_wbv", wb_valid, 1);
                chk("ld_data", wb_data, e_ld);
                chk("ld_rd", 32'(wb_rd), 32'(rd));
                chk("ld_busy", ex_ready, 0);
                chk("ld_noerr", lsu_err, 0);
            end
            step();
            dm_rvalid = 1'b0;
            chk("end_noerr", lsu_err, 0);
            chk("end_nowb", wb_valid, 0);
            chk("end_ready", ex_ready, 1);
            chk("end_eaddr", err_addr, err_addr_m);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, ex_ready, 1);
        chk({tag, "_req"}, dm_req, 0);
        chk({tag, "_we"}, dm_we, 0);
        chk({tag, "_addr"}, dm_addr, 0);
        chk({tag, "_be"}, 32'(dm_be), 0);
        chk({tag, "_wdata"}, dm_wdata, 0);
        chk({tag, "_wbv"}, wb_valid, 0);
        chk({tag, "_wbrd"}, 32'(wb_rd), 0);
        chk({tag, "_wbdata"}, wb_data, 0);
        chk({tag, "_err"}, lsu_err, 0);
        chk({tag, "_eaddr"}, err_addr, 0);
    endtask

    // Reset while waiting for a load response; the late response must be dropped
    task automatic reset_mid_wait();
        chk("rw_ready", ex_ready, 1);
        ex_valid  = 1'b1;
        ex_load   = 1'b1;
        ex_store  = 1'b0;
        ex_funct3 = 3'b010;
        ex_addr   = 32'h0000_4000;
        ex_rd     = 5'd9;
        step();
        ex_valid = 1'b0;
        ex_load  = 1'b0;
        dm_gnt   = 1'b1;
        step();
        dm_gnt = 1'b0;
        chk("rw_inwait", dm_req, 0);
        reset = 1'b1;
        step();
        reset     = 1'b0;
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h1234_5678;
        check_reset_values("rw");
        step();
        dm_rvalid = 1'b0;
        chk("rw_late_nowb", wb_valid, 0);
        chk("rw_late_noerr", lsu_err, 0);
        chk("rw_late_ready", ex_ready, 1);
        chk("rw_late_noreq", dm_req, 0);
        err_addr_m = '0;
    endtask

    initial begin
        reset     = 1'b1;
        ex_valid  = 1'b0;
        ex_load   = 1'b0;
        ex_store  = 1'b0;
        ex_funct3 = '0;
        ex_addr   = '0;
        ex_wdata  = '0;
        ex_rd     = '0;
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        step();

        run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 0, 0, 32'h8012_3456);
        run_op(1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd6, 0, 0, 32'h8012_3456);
        run_op(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 5'd0, 0, 0, 32'h0);
        run_op(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd17, 3, 1, 32'hCAFE_F00D);
        run_op(1'b0, 3'b010, 32'h0000_1001, 32'h0, 5'd3, 0, 0, 32'h1122_3344);
        run_op(1'b0, 3'b101, 32'h0000_5003, 32'h0, 5'd4, 1, 0, 32'h89AB_CDEF);
        run_op(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd7, 20, 0, 32'h0);
        run_op(1'b1, 3'b010, 32'h0000_7004, 32'hDEAD_BEEF, 5'd0, 2, 9, 32'h0);

        // Ignored: ex_valid with neither load nor store
        ex_valid = 1'b1;
        ex_load  = 1'b0;
        ex_store = 1'b0;
        step();
        ex_valid = 1'b0;
        chk("nokind_ready", ex_ready, 1);
        chk("nokind_noreq", dm_req, 0);
        step();
        chk("nokind_noreq2", dm_req, 0);

        reset_mid_wait();

        for (int k = 0; k < 80; k++) begin
            bit          st;
            logic [2:0]  f3;
            st = 1'($urandom % 2);
            f3 = st ? 3'($urandom % 3) : 3'($urandom % 8);
            run_op(st, f3, $urandom, $urandom, 5'($urandom), int'($urandom % 5),
                   int'($urandom % 5), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
